// File: rtl/spu_pkg.sv
// Shared types and constants for the SPU decode stage.
package spu_pkg;

  localparam int REG_AW        = 7;
  localparam int NUM_REG_SLOTS = 1 << REG_AW;

  typedef enum logic [2:0] {
    FMT_RR   = 3'd0,
    FMT_RRR  = 3'd1,
    FMT_RI7  = 3'd2,
    FMT_RI10 = 3'd3,
    FMT_RI16 = 3'd4,
    FMT_RI18 = 3'd5
  } spu_fmt_t;

  // Register field positions within the instruction word
  localparam int RB_LSB     = 14;
  localparam int RA_LSB     = 7;
  localparam int RC_LSB     = 0;
  localparam int RT_RRR_LSB = 21;
  localparam int RT_LSB     = 0;

  // Immediate field positions and widths
  localparam int RI7_LSB  = 14;
  localparam int RI7_W    = 7;
  localparam int RI10_LSB = 14;
  localparam int RI10_W   = 10;
  localparam int RI16_LSB = 7;
  localparam int RI16_W   = 16;
  localparam int RI18_LSB = 7;
  localparam int RI18_W   = 18;

  // Reserved format codes decode as RR
  function automatic spu_fmt_t norm_fmt(input logic [2:0] f);
    case (f)
      3'd1:    return FMT_RRR;
      3'd2:    return FMT_RI7;
      3'd3:    return FMT_RI10;
      3'd4:    return FMT_RI16;
      3'd5:    return FMT_RI18;
      default: return FMT_RR;
    endcase
  endfunction

  function automatic logic reg_in_range(input logic [REG_AW-1:0] a, input int n);
    return (int'({25'd0, a}) < n);
  endfunction

endpackage

// File: rtl/spu_regfile.sv
// Register file: three combinational read ports, one synchronous write port.
// Addresses at or above NUM_REGS read as zero and ignore writes.
module spu_regfile
  import spu_pkg::*;
#(
  parameter int DATA_W   = 128,
  parameter int NUM_REGS = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr_a,
  input  logic [REG_AW-1:0] i_raddr_b,
  input  logic [REG_AW-1:0] i_raddr_c,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b,
  output logic [DATA_W-1:0] o_rdata_c
);

  // Slots above NUM_REGS are never written, so they stay at their reset value
  logic [DATA_W-1:0] r_mem [NUM_REG_SLOTS];

  // Write port with async clear of every entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REG_SLOTS; i++) r_mem[i] <= '0;
    end else if (i_we && reg_in_range(i_waddr, NUM_REGS)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = reg_in_range(i_raddr_a, NUM_REGS) ? r_mem[i_raddr_a] : '0;
  assign o_rdata_b = reg_in_range(i_raddr_b, NUM_REGS) ? r_mem[i_raddr_b] : '0;
  assign o_rdata_c = reg_in_range(i_raddr_c, NUM_REGS) ? r_mem[i_raddr_c] : '0;

endmodule

// File: rtl/spu_decode_stage.sv
// SPU decode stage: field extraction, immediate generation, busy-bit
// scoreboard and a single registered output slot.
// Optional writeback-to-operand bypass: define SPU_DEC_BYPASS_EN.
module spu_decode_stage
  import spu_pkg::*;
#(
  parameter int DATA_W   = 128,
  parameter int NUM_REGS = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_instr,
  input  logic [2:0]        in_fmt,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [2:0]        out_fmt,
  output logic [REG_AW-1:0] out_rt,
  output logic [DATA_W-1:0] out_ra_data,
  output logic [DATA_W-1:0] out_rb_data,
  output logic [DATA_W-1:0] out_rc_data,
  output logic [DATA_W-1:0] out_imm
);

  localparam int WORDS = DATA_W / 32;

  spu_fmt_t          w_fmt;
  logic [REG_AW-1:0] w_ra, w_rb, w_rc, w_rt;
  logic              w_use_a, w_use_b, w_use_c;
  logic [31:0]       w_imm32;
  logic [DATA_W-1:0] w_rf_a, w_rf_b, w_rf_c;
  logic [DATA_W-1:0] w_src_a, w_src_b, w_src_c;
  logic              w_byp_a, w_byp_b, w_byp_c;
  logic              w_hazard, w_accept;
  logic [NUM_REG_SLOTS-1:0] w_busy_nxt;
  logic              w_unused;

  logic [NUM_REG_SLOTS-1:0] r_busy;
  logic              r_out_valid;
  logic [31:0]       r_pc;
  logic [2:0]        r_fmt;
  logic [REG_AW-1:0] r_rt;
  logic [DATA_W-1:0] r_ra_data, r_rb_data, r_rc_data, r_imm;

  // Bits [31:28] carry the opcode, which this stage does not interpret
  assign w_unused = &{1'b0, in_instr[31:28]};

  assign w_fmt = norm_fmt(in_fmt);
  assign w_ra  = in_instr[RA_LSB +: REG_AW];
  assign w_rb  = in_instr[RB_LSB +: REG_AW];
  assign w_rc  = in_instr[RC_LSB +: REG_AW];
  assign w_rt  = (w_fmt == FMT_RRR) ? in_instr[RT_RRR_LSB +: REG_AW]
                                    : in_instr[RT_LSB +: REG_AW];

  // Source usage and 32-bit immediate per format
  always_comb begin
    w_use_a = 1'b0;
    w_use_b = 1'b0;
    w_use_c = 1'b0;
    w_imm32 = '0;
    case (w_fmt)
      FMT_RRR: begin
        w_use_a = 1'b1;
        w_use_b = 1'b1;
        w_use_c = 1'b1;
      end
      FMT_RI7: begin
        w_use_a = 1'b1;
        w_imm32 = {{(32-RI7_W){in_instr[RI7_LSB+RI7_W-1]}}, in_instr[RI7_LSB +: RI7_W]};
      end
      FMT_RI10: begin
        w_use_a = 1'b1;
        w_imm32 = {{(32-RI10_W){in_instr[RI10_LSB+RI10_W-1]}}, in_instr[RI10_LSB +: RI10_W]};
      end
      FMT_RI16: begin
        w_imm32 = {{(32-RI16_W){in_instr[RI16_LSB+RI16_W-1]}}, in_instr[RI16_LSB +: RI16_W]};
      end
      FMT_RI18: begin
        w_imm32 = {{(32-RI18_W){1'b0}}, in_instr[RI18_LSB +: RI18_W]};
      end
      default: begin
        w_use_a = 1'b1;
        w_use_b = 1'b1;
      end
    endcase
  end

  spu_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .i_we      (wb_en),
    .i_waddr   (wb_addr),
    .i_wdata   (wb_data),
    .i_raddr_a (w_ra),
    .i_raddr_b (w_rb),
    .i_raddr_c (w_rc),
    .o_rdata_a (w_rf_a),
    .o_rdata_b (w_rf_b),
    .o_rdata_c (w_rf_c)
  );

`ifdef SPU_DEC_BYPASS_EN
  assign w_byp_a = wb_en && (wb_addr == w_ra) && reg_in_range(w_ra, NUM_REGS);
  assign w_byp_b = wb_en && (wb_addr == w_rb) && reg_in_range(w_rb, NUM_REGS);
  assign w_byp_c = wb_en && (wb_addr == w_rc) && reg_in_range(w_rc, NUM_REGS);
`else
  assign w_byp_a = 1'b0;
  assign w_byp_b = 1'b0;
  assign w_byp_c = 1'b0;
`endif

  assign w_src_a = w_byp_a ? wb_data : w_rf_a;
  assign w_src_b = w_byp_b ? wb_data : w_rf_b;
  assign w_src_c = w_byp_c ? wb_data : w_rf_c;

  // A bypassed source is about to be cleared, so it never stalls
  assign w_hazard = in_valid &&
                    ((w_use_a && r_busy[w_ra] && !w_byp_a) ||
                     (w_use_b && r_busy[w_rb] && !w_byp_b) ||
                     (w_use_c && r_busy[w_rc] && !w_byp_c));

  assign in_ready = reset && !w_hazard && (!r_out_valid || out_ready) && !flush;
  assign w_accept = in_valid && in_ready;

  // Scoreboard next state: clear on writeback, set on accept (set wins), flush clears all
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_en) w_busy_nxt[wb_addr] = 1'b0;
    if (w_accept && reg_in_range(w_rt, NUM_REGS)) w_busy_nxt[w_rt] = 1'b1;
    if (flush) w_busy_nxt = '0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  // Output slot: load on accept, hold under backpressure, drop after transfer or flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_pc        <= '0;
      r_fmt       <= '0;
      r_rt        <= '0;
      r_ra_data   <= '0;
      r_rb_data   <= '0;
      r_rc_data   <= '0;
      r_imm       <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_pc        <= in_pc;
      r_fmt       <= in_fmt;
      r_rt        <= w_rt;
      r_ra_data   <= w_use_a ? w_src_a : '0;
      r_rb_data   <= w_use_b ? w_src_b : '0;
      r_rc_data   <= w_use_c ? w_src_c : '0;
      r_imm       <= {WORDS{w_imm32}};
    end else if (flush || out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_pc      = r_pc;
  assign out_fmt     = r_fmt;
  assign out_rt      = r_rt;
  assign out_ra_data = r_ra_data;
  assign out_rb_data = r_rb_data;
  assign out_rc_data = r_rc_data;
  assign out_imm     = r_imm;

endmodule
